muldiv_iter: RTL and testbench
==============================

# muldiv_iter

Multi-cycle, parametrised RV32M/RV64M multiply/divide unit with its own sequencer. It sits beside the single-cycle ALU datapath in the execute stage. The ALU issues M-extension operations to it through a start/valid handshake and holds the pipeline while `busy_o` is high. It replaces the external-divider handshake with an internal iterative engine that covers all eight M operations and the RISC-V corner cases.

## Interface
- `WIDTH`, 32: operand/result width. Must be even and ≥ 8; the bench covers 32 and 64.
- `CNT_W`, `$clog2(WIDTH)+1`: iteration counter width. Derived; do not override.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request. Accepted only in IDLE.
- `op_i`  in  3  operation, funct3 order: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src1_i`  in  WIDTH  rs1 / dividend. Sampled only at accept.
- `src2_i`  in  WIDTH  rs2 / divisor. Sampled only at accept.
- `flush_i`  in  1  kill the in-flight operation (pipeline flush).
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `res_valid_o`  out  1  one-cycle pulse: `res_o` is new.
- `res_o`  out  WIDTH  result. Registered; holds its value until the next result.

## Operation
- States: IDLE, MUL, DIV, ADJ, DONE.
- Accept happens when `start_i && state==IDLE && !flush_i`. At accept the unit latches op, operand magnitudes (two's-complement negate where the op treats the operand as signed and its MSB is set), the result sign, and the remainder sign.
- Transitions:
  - IDLE→MUL on an accepted mul op.
  - IDLE→DIV on an accepted div op.
  - IDLE→DONE on a fast-path case.
  - MUL/DIV→ADJ when the counter reaches WIDTH iterations.
  - ADJ→DONE.
  - DONE→IDLE.
- MUL: radix-2 shift-add on magnitudes into a 2·WIDTH product, one bit per cycle. In ADJ, negate the product if the result sign is set. Output the low half for MUL and the high half for the other mul ops.
- Signedness: MULH treats both operands as signed, MULHSU treats only src1 as signed, and MULHU/MUL treat both as unsigned. MUL's low half is sign-independent.
- DIV: restoring division on magnitudes, one quotient bit per cycle. In ADJ:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Fast paths (IDLE→DONE, no iterations):
  - Divisor = 0: DIV/DIVU return all ones; REM/REMU return src1.
  - Signed overflow (DIV/REM with src1 = 1 followed by WIDTH-1 zeros and src2 = all ones): DIV returns src1; REM returns 0.
- `flush_i` high in any state: next state is IDLE, no `res_valid_o`, and `res_o` is unchanged. `flush_i` and `start_i` in the same IDLE cycle: flush wins and the request is dropped.
- `start_i` outside IDLE is ignored. This includes DONE, where back-to-back issue is not supported.
- Reset values:
  - state IDLE.
  - `busy_o` 0.
  - `res_valid_o` 0.
  - `res_o` 0.
  - counter and internal registers 0.
- `rst` mid-operation aborts exactly like a flush and also clears `res_o`.

## Timing
- Accept cycle is T.
- `busy_o` is high from T+1 until the DONE cycle inclusive. It is low in T itself because it is registered.
- Iterative ops:
  - MUL/DIV states cover T+1 … T+WIDTH.
  - ADJ at T+WIDTH+1.
  - DONE with `res_valid_o`=1 at T+WIDTH+2.
  - Latency is WIDTH+2; 34 for WIDTH=32.
- Fast path: DONE with `res_valid_o` at T+1.
- Earliest next accept is T+WIDTH+3 (iterative) or T+2 (fast path).

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - Defined: all mul ops use a single combinational WIDTH×WIDTH signed-corrected multiply registered into DONE, with result at T+1. MUL and ADJ states are not used for multiplies.
  - Undefined: multiplies are iterative, with WIDTH+2 latency.
  - Divide behaviour is identical in both builds.

## Test plan
- Signed divide: DIV src1=0xFFFFFFF9 (−7), src2=2 → `res_o`=0xFFFFFFFD at T+34. REM on the same operands → 0xFFFFFFFF. `busy_o` is high T+1…T+34.
- Divide by zero: DIVU 100/0 → 0xFFFFFFFF with `res_valid_o` at T+1. REMU 100/0 → 100. DIV 0xFFFFFFFF/0 → 0xFFFFFFFF.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1. REM on the same operands → 0.
- Multiply signedness, src1=src2=0xFFFFFFFF:
  - MUL → 0x00000001.
  - MULH → 0x00000000.
  - MULHU → 0xFFFFFFFE.
  - MULHSU → 0xFFFFFFFF.
  - Latency is 34 without `MULDIV_FAST_MUL_EN` and 1 with it.
- Flush and ignore:
  - Start DIVU 1000/7, then pulse `flush_i` at T+10: IDLE at T+11, no `res_valid_o`, and `res_o` keeps its prior value.
  - `start_i` held during busy is ignored.
  - `start_i` and `flush_i` together in IDLE → no accept.
- Reset mid-operation: assert `rst` at T+5 of a MULHU → all outputs 0 next cycle. A new DIV accepted afterwards produces the correct result.

Source files
------------

// File: rtl/muldiv_iter_if.sv
// Issue/result bundle between the execute-stage ALU and the iterative multiply/divide unit.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             flush_i;
  logic             busy_o;
  logic             res_valid_o;
  logic [WIDTH-1:0] res_o;

  modport master (
    output start_i, op_i, src1_i, src2_i, flush_i,
    input  busy_o, res_valid_o, res_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i, flush_i,
    output busy_o, res_valid_o, res_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a one-cycle combinational one.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_iter_if.slave  bus
);
  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_ADJ, ST_DONE} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         op_reg, op_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [2*WIDTH-1:0] p_reg, p_next;
  logic               neg_res_reg, neg_res_next;
  logic               neg_rem_reg, neg_rem_next;
  logic [WIDTH-1:0]   res_reg, res_next;
  logic               valid_reg, valid_next;

  logic             src1_signed, src2_signed, src1_neg, src2_neg;
  logic [WIDTH-1:0] src1_mag, src2_mag, int_min;
  logic             div_zero, div_ovf;

  assign int_min     = {1'b1, {(WIDTH-1){1'b0}}};
  assign src1_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
                       (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
  assign src2_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
  assign src1_neg    = src1_signed && bus.src1_i[WIDTH-1];
  assign src2_neg    = src2_signed && bus.src2_i[WIDTH-1];
  assign src1_mag    = src1_neg ? -bus.src1_i : bus.src1_i;
  assign src2_mag    = src2_neg ? -bus.src2_i : bus.src2_i;
  assign div_zero    = bus.op_i[2] && (bus.src2_i == '0);
  assign div_ovf     = ((bus.op_i == 3'b100) || (bus.op_i == 3'b110)) &&
                       (bus.src1_i == int_min) && (bus.src2_i == '1);

  // p_reg holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  assign mul_sum   = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, (p_reg[0] ? a_reg : {WIDTH{1'b0}})};
  assign div_shift = {p_reg[2*WIDTH-1:WIDTH], p_reg[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, a_reg};
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - a_reg) : div_shift[WIDTH-1:0];

  logic [2*WIDTH-1:0] prod_adj;
  logic [WIDTH-1:0]   quo_adj, rem_adj, adj_res;

  assign prod_adj = neg_res_reg ? -p_reg : p_reg;
  assign quo_adj  = neg_res_reg ? -p_reg[WIDTH-1:0] : p_reg[WIDTH-1:0];
  assign rem_adj  = neg_rem_reg ? -p_reg[2*WIDTH-1:WIDTH] : p_reg[2*WIDTH-1:WIDTH];
  assign adj_res  = op_reg[2] ? (op_reg[1] ? rem_adj : quo_adj) :
                    ((op_reg == 3'b000) ? prod_adj[WIDTH-1:0] : prod_adj[2*WIDTH-1:WIDTH]);

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extending both operands to 2*WIDTH makes a plain modular multiply signed-correct
  logic [2*WIDTH-1:0] fast_prod;
  logic [WIDTH-1:0]   fast_res;
  assign fast_prod = {{WIDTH{src1_neg}}, bus.src1_i} * {{WIDTH{src2_neg}}, bus.src2_i};
  assign fast_res  = (bus.op_i == 3'b000) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    cnt_next     = cnt_reg;
    a_next       = a_reg;
    p_next       = p_reg;
    neg_res_next = neg_res_reg;
    neg_rem_next = neg_rem_reg;
    res_next     = res_reg;
    valid_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start_i) begin
          op_next      = bus.op_i;
          a_next       = src2_mag;
          p_next       = {{WIDTH{1'b0}}, src1_mag};
          cnt_next     = '0;
          neg_res_next = src1_neg ^ src2_neg;
          neg_rem_next = src1_neg;
          if (div_zero) begin
            res_next   = bus.op_i[1] ? bus.src1_i : {WIDTH{1'b1}};
            valid_next = 1'b1;
            state_next = ST_DONE;
          end else if (div_ovf) begin
            res_next   = bus.op_i[1] ? {WIDTH{1'b0}} : bus.src1_i;
            valid_next = 1'b1;
            state_next = ST_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!bus.op_i[2]) begin
            res_next   = fast_res;
            valid_next = 1'b1;
            state_next = ST_DONE;
          end
`endif
          else begin
            state_next = bus.op_i[2] ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL: begin
        p_next   = {mul_sum, p_reg[WIDTH-1:1]};
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(WIDTH-1)) state_next = ST_ADJ;
      end
      ST_DIV: begin
        p_next   = {div_rem, p_reg[WIDTH-2:0], div_ge};
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(WIDTH-1)) state_next = ST_ADJ;
      end
      ST_ADJ: begin
        res_next   = adj_res;
        valid_next = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // A flush kills everything, including a same-cycle request, and leaves the old result visible
    if (bus.flush_i) begin
      state_next = ST_IDLE;
      valid_next = 1'b0;
      res_next   = res_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      op_reg      <= '0;
      cnt_reg     <= '0;
      a_reg       <= '0;
      p_reg       <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      res_reg     <= '0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      cnt_reg     <= cnt_next;
      a_reg       <= a_next;
      p_reg       <= p_next;
      neg_res_reg <= neg_res_next;
      neg_rem_reg <= neg_rem_next;
      res_reg     <= res_next;
      valid_reg   <= valid_next;
    end
  end

  assign bus.busy_o      = (state_reg != ST_IDLE);
  assign bus.res_valid_o = valid_reg;
  assign bus.res_o       = res_reg;
endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed corner cases, flush/reset aborts and a random sweep.
module tb_muldiv_iter;
  localparam int WIDTH    = 32;
  localparam int ITER_LAT = WIDTH + 2;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = ITER_LAT;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(WIDTH)) bus();
  muldiv_iter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return ITER_LAT;
  endfunction

  // Issue one op; with hold, start stays high (with junk operands) until the result appears
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit hold, input string name);
    logic [31:0] want;
    bit          seen;
    int          got_k;
    seen  = 1'b0;
    got_k = -1;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    exp_q.push_back(exp);
    @(negedge clk);
    if (hold) begin
      bus.op_i   = ~op;
      bus.src1_i = ~a;
      bus.src2_i = b + 32'd1;
    end else begin
      bus.start_i = 1'b0;
    end
    for (int k = 1; k <= lat + 4 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= lat) begin
        n_vec++;
        if (bus.busy_o !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy at T+%0d: got %b want 1", name, k, bus.busy_o);
        end
      end
      if (bus.res_valid_o === 1'b1) begin
        seen  = 1'b1;
        got_k = k;
        bus.start_i = 1'b0;
        want = exp_q.pop_front();
        n_vec++;
        if (k != lat) begin
          n_err++;
          $display("FAIL %s latency: got %0d want %0d", name, k, lat);
        end
        n_vec++;
        if (bus.res_o !== want) begin
          n_err++;
          $display("FAIL %s result: got %h want %h", name, bus.res_o, want);
        end
      end
    end
    bus.start_i = 1'b0;
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s timeout: no res_valid within %0d cycles", name, lat + 4);
      exp_q.delete();
    end
    @(negedge clk);
    n_vec++;
    if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0 || bus.res_o !== exp) begin
      n_err++;
      $display("FAIL %s after DONE: busy=%b valid=%b res=%h want busy=0 valid=0 res=%h",
               name, bus.busy_o, bus.res_valid_o, bus.res_o, exp);
    end
    last_res = exp;
    $display("%s op=%0d a=%h b=%h res=%h exp=%h lat=%0d", name, op, a, b, bus.res_o, exp, got_k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = '0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0 || bus.res_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset: busy=%b valid=%b res=%h want 0/0/0", bus.busy_o, bus.res_valid_o, bus.res_o);
    end
    rst = 1'b0;
    $display("reset busy=%b valid=%b res=%h", bus.busy_o, bus.res_valid_o, bus.res_o);
  endtask

  task automatic test_divide();
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, ITER_LAT, 1'b0, "div_neg7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, ITER_LAT, 1'b0, "rem_neg7_2");
    run_op(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, ITER_LAT, 1'b0, "div_100_neg7");
    run_op(3'b110, 32'd100, 32'hFFFF_FFF9, 32'd2, ITER_LAT, 1'b0, "rem_100_neg7");
    run_op(3'b101, 32'd1000, 32'd7, 32'd142, ITER_LAT, 1'b0, "divu_1000_7");
    run_op(3'b111, 32'd1000, 32'd7, 32'd6, ITER_LAT, 1'b0, "remu_1000_7");
  endtask

  task automatic test_div_zero();
    run_op(3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, "divu_by0");
    run_op(3'b111, 32'd100, 32'd0, 32'd100, 1, 1'b0, "remu_by0");
    run_op(3'b100, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, "div_by0");
    run_op(3'b110, 32'd5, 32'd0, 32'd5, 1, 1'b0, "rem_by0");
  endtask

  task automatic test_overflow();
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, "rem_ovf");
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, ITER_LAT, 1'b0, "divu_no_ovf");
  endtask

  task automatic test_mul();
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT, 1'b0, "mul_m1");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 1'b0, "mulh_m1");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0, "mulhu_m1");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b0, "mulhsu_m1");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 1'b0, "mulh_min");
    run_op(3'b000, 32'd7, 32'd6, 32'd42, MUL_LAT, 1'b0, "mul_7_6");
  endtask

  task automatic test_hold_start();
    run_op(3'b101, 32'd1000, 32'd7, 32'd142, ITER_LAT, 1'b1, "hold_divu");
    run_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, ref_res(3'b011, 32'h1234_5678, 32'h9ABC_DEF0),
           MUL_LAT, 1'b1, "hold_mulhu");
  endtask

  task automatic test_flush();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = 3'b101;
    bus.src1_i  = 32'd1000;
    bus.src2_i  = 32'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    n_vec++;
    if (bus.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush busy at T+10: got %b want 1", bus.busy_o);
    end
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    n_vec++;
    if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0 || bus.res_o !== last_res) begin
      n_err++;
      $display("FAIL flush at T+11: busy=%b valid=%b res=%h want 0/0/%h",
               bus.busy_o, bus.res_valid_o, bus.res_o, last_res);
    end
    repeat (40) begin
      @(negedge clk);
      if (bus.res_valid_o === 1'b1 || bus.res_o !== last_res) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL flush aftermath: res_valid or res_o changed, res=%h want %h", bus.res_o, last_res);
    end
    $display("flush divu busy=%b res=%h kept=%h", bus.busy_o, bus.res_o, last_res);
  endtask

  task automatic test_start_flush();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i    = 3'b101;
    bus.src1_i  = 32'd9;
    bus.src2_i  = 32'd0;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    n_vec++;
    if (bus.busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL start_flush busy: got %b want 0", bus.busy_o);
    end
    repeat (4) begin
      if (bus.res_valid_o === 1'b1 || bus.res_o !== last_res) seen = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL start_flush accepted: res=%h want %h", bus.res_o, last_res);
    end
    $display("start_flush busy=%b res=%h", bus.busy_o, bus.res_o);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = 3'b011;
    bus.src1_i  = 32'hDEAD_BEEF;
    bus.src2_i  = 32'h1234_5678;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0 || bus.res_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b valid=%b res=%h want 0/0/0", bus.busy_o, bus.res_valid_o, bus.res_o);
    end
    $display("reset_mid busy=%b valid=%b res=%h", bus.busy_o, bus.res_valid_o, bus.res_o);
    last_res = 32'h0;
    run_op(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, ITER_LAT, 1'b0, "div_after_rst");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (i % 3 == 1) b = 32'($urandom_range(1, 300));
      run_op(op, a, b, ref_res(op, a, b), ref_lat(op, a, b), 1'b0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_overflow();
    test_mul();
    test_hold_start();
    test_flush();
    test_start_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
